// File: rtl/control_rtc_param.sv
// RTC access controller: decodes PicoBlaze addresses into RTC register indices,
// runs bus-driver write/read handshakes with a timeout, and keeps a shadow copy.
module control_rtc_param #(
  parameter int          DW     = 8,
  parameter int          AW     = 8,
  parameter int          NREG   = 16,
  parameter logic [AW-1:0] BASE_A = 8'h21,
  parameter int          LEN_A  = 6,
  parameter logic [AW-1:0] BASE_B = 8'h41,
  parameter int          LEN_B  = 3,
  parameter logic [AW-1:0] LOC0   = 8'h0A,
  parameter logic [AW-1:0] LOC1   = 8'h0B,
  parameter int          TMO    = 1023,
  localparam int         IW     = $clog2(NREG),
  localparam int         CW     = $clog2(TMO+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          writestrobe,
  input  logic          readstrobe,
  input  logic [AW-1:0] dir,
  input  logic [DW-1:0] dato,
  input  logic [DW-1:0] datomem,
  input  logic          esclisto,
  input  logic          memorialisto,
  output logic          actesc,
  output logic          actlec,
  output logic [IW-1:0] dirmem,
  output logic [DW-1:0] datoreg,
  output logic [DW-1:0] datoout,
  output logic          listo,
  output logic          err,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, DECODE, LOCAL, WR_REQ, RD_REQ, FAIL, DONE} state_t;

  state_t state, state_n;

  logic [AW-1:0]            dir_l;
  logic [DW-1:0]            dato_l;
  logic                     wr_l, rd_l;
  logic [CW-1:0]            cnt, cnt_inc;
  logic                     tmo;
  logic [NREG-1:0][DW-1:0]  shadow;

  logic [AW-1:0] off_a, off_b;
  logic [IW-1:0] idx_dec;
  logic          is_loc;

  // Unsigned wrap makes "offset < length" a complete range check.
  assign off_a = dir_l - BASE_A;
  assign off_b = dir_l - BASE_B;

  always_comb begin
    idx_dec = '0;
    is_loc  = 1'b0;
    if (off_a < AW'(LEN_A))
      idx_dec = IW'(off_a) + IW'(1);
    else if (off_b < AW'(LEN_B))
      idx_dec = IW'(off_b) + IW'(LEN_A + 1);
    else if (dir_l == LOC0) begin
      idx_dec = IW'(LEN_A + LEN_B + 1);
      is_loc  = 1'b1;
    end else if (dir_l == LOC1) begin
      idx_dec = IW'(LEN_A + LEN_B + 2);
      is_loc  = 1'b1;
    end
  end

  assign cnt_inc = cnt + CW'(1);
  assign tmo     = (cnt_inc == CW'(TMO));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // An ack in the timeout cycle takes priority over the timeout.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (cs) state_n = DECODE;
      DECODE: begin
        if (wr_l == rd_l || idx_dec == '0) state_n = FAIL;
        else if (is_loc)                   state_n = LOCAL;
        else if (wr_l)                     state_n = WR_REQ;
        else                               state_n = RD_REQ;
      end
      LOCAL:  state_n = DONE;
      WR_REQ: begin
        if (esclisto) state_n = DONE;
        else if (tmo) state_n = FAIL;
      end
      RD_REQ: begin
        if (memorialisto) state_n = DONE;
        else if (tmo)     state_n = FAIL;
      end
      FAIL:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_l   <= '0;
      dato_l  <= '0;
      wr_l    <= 1'b0;
      rd_l    <= 1'b0;
      cnt     <= '0;
      shadow  <= '0;
      actesc  <= 1'b0;
      actlec  <= 1'b0;
      dirmem  <= '0;
      datoreg <= '0;
      datoout <= '0;
      listo   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          listo   <= 1'b0;
          datoout <= '0;
          err     <= 1'b0;
          if (cs) begin
            dir_l  <= dir;
            dato_l <= dato;
            wr_l   <= writestrobe;
            rd_l   <= readstrobe;
            busy   <= 1'b1;
          end
        end
        DECODE: begin
          dirmem <= idx_dec;
          if (state_n == WR_REQ) begin
            actesc  <= 1'b1;
            datoreg <= dato_l;
          end
          if (state_n == RD_REQ) actlec <= 1'b1;
        end
        LOCAL: begin
          if (wr_l) shadow[dirmem] <= dato_l;
          else      datoout        <= shadow[dirmem];
          err <= 1'b0;
        end
        WR_REQ: begin
          cnt <= cnt_inc;
          if (state_n != WR_REQ) actesc <= 1'b0;
          if (esclisto) shadow[dirmem] <= dato_l;
        end
        RD_REQ: begin
          cnt <= cnt_inc;
          if (state_n != RD_REQ) actlec <= 1'b0;
          if (memorialisto) begin
            datoout        <= datomem;
            shadow[dirmem] <= datomem;
          end
        end
        FAIL: begin
          datoout <= '0;
          err     <= 1'b1;
        end
        DONE: begin
          listo  <= 1'b1;
          busy   <= 1'b0;
          actesc <= 1'b0;
          actlec <= 1'b0;
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
